// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder family: sequencer states, slice width
// and an elaboration-time log2 helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/nibble_adder_4.sv
// Combinational 4-bit adder slice with carry in and carry out; the only
// arithmetic in the serial adder.
module nibble_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder built from one 4-bit slice reused over WIDTH/4 cycles.
// Define NIBBLE_SUB_EN to add a 'sub' input that turns the operation into X - Y.
module nibble_serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk1,
  input  logic             rst1,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
`ifdef NIBBLE_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             C
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = clog2(NIB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  state_t             state;
  logic [WIDTH-1:0]   x_sr;
  logic [WIDTH-1:0]   y_sr;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt;
  logic [NIBBLE_W-1:0] y_nib;
  logic [NIBBLE_W-1:0] slice_sum;
  logic               slice_co;

`ifdef NIBBLE_SUB_EN
  logic sub_q;

  // Subtraction is X + ~Y + 1: invert each Y nibble, the +1 comes from the preset carry.
  assign y_nib = y_sr[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_q}};
`else
  assign y_nib = y_sr[NIBBLE_W-1:0];
`endif

  nibble_adder_4 u_slice (
    .a  (x_sr[NIBBLE_W-1:0]),
    .b  (y_nib),
    .ci (carry_q),
    .s  (slice_sum),
    .co (slice_co)
  );

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values, independent of statement order.
  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      state   <= IDLE;
      x_sr    <= '0;
      y_sr    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      Sum     <= '0;
      C       <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
`ifdef NIBBLE_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      // Registered view of RUN/DONE: rises one cycle after acceptance, falls with done.
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            x_sr  <= X;
            y_sr  <= Y;
            cnt   <= '0;
            Sum   <= '0;
            C     <= 1'b0;
`ifdef NIBBLE_SUB_EN
            sub_q   <= sub;
            carry_q <= sub;
`else
            carry_q <= 1'b0;
`endif
            state <= RUN;
          end
        end
        RUN: begin
          x_sr    <= x_sr >> NIBBLE_W;
          y_sr    <= y_sr >> NIBBLE_W;
          carry_q <= slice_co;
          // New nibble enters at the top so nibble 0 ends up at Sum[3:0].
          Sum     <= {slice_sum, Sum[WIDTH-1:NIBBLE_W]};
          if (cnt == LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          C     <= carry_q;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl (WIDTH=16): the driver queues the
// hand-computed result of each accepted operation, the monitor checks each done.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             c;
    string            tag;
  } exp_t;

  logic             clk1;
  logic             rst1;
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             sub_r;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             C;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk1  (clk1),
    .rst1  (rst1),
    .start (start),
    .X     (X),
    .Y     (Y),
`ifdef NIBBLE_SUB_EN
    .sub   (sub_r),
`endif
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .C     (C)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Presents one operand pair with a single-cycle start pulse; returns at edge 0 + 1.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_c,
                       input bit expect_result, input string tag);
    exp_t e;
    @(posedge clk1);
    #1;
    X     = x;
    Y     = y;
    sub_r = s;
    start = 1'b1;
    if (expect_result) begin
      e.sum = exp_sum;
      e.c   = exp_c;
      e.tag = tag;
      exp_q.push_back(e);
    end
    @(posedge clk1);
    #1;
    start = 1'b0;
  endtask

  // Counts negedges until done; the first negedge after the accepting edge is 1.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (n < 30) begin
      @(negedge clk1);
      n++;
      if (done) break;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", tag, n);
    end
  endtask

  // Monitor: scoreboard compare on every done, plus busy/done framing.
  initial begin
    int  busy_len;
    bit  prev_busy;
    bit  prev_done;
    exp_t e;
    busy_len  = 0;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk1);
      if (rst1) begin
        busy_len  = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) check("busy_low_after_done", 32'(busy), 32'd0);
        if (done) begin
          check("busy_with_done", 32'(busy), 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: Sum=0x%0h C=%0b with no operation pending", Sum, C);
          end else begin
            e = exp_q.pop_front();
            check({e.tag, "_sum"}, 32'(Sum), 32'(e.sum));
            check({e.tag, "_c"}, 32'(C), 32'(e.c));
          end
        end
        if (busy) begin
          busy_len++;
        end else if (prev_busy) begin
          check("busy_len", 32'(busy_len), 32'(NIB + 1));
          busy_len = 0;
        end
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  initial begin
    int n;
    int done_cyc[$];
    n_checks = 0;
    n_fail   = 0;
    rst1  = 1'b1;
    start = 1'b0;
    X     = '0;
    Y     = '0;
    sub_r = 1'b0;

    repeat (2) @(posedge clk1);
    #1;
    rst1 = 1'b0;
    @(negedge clk1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(Sum), 32'd0);
    check("reset_c", 32'(C), 32'd0);

    // Basic add with latency and hold check
    issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b1, "add_1234");
    wait_done("add_1234", n);
    check("latency", 32'(n - 1), 32'(NIB + 1));
    repeat (3) @(negedge clk1);
    check("sum_held", 32'(Sum), 32'h2345);
    check("c_held", 32'(C), 32'd0);

    // Carry ripples through every pass
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, "add_ffff");
    wait_done("add_ffff", n);
    check("latency_ffff", 32'(n - 1), 32'(NIB + 1));

    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "add_msb");
    wait_done("add_msb", n);

    issue(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b1, "add_abcd");
    wait_done("add_abcd", n);

    // Start re-pulsed while running is ignored; operand change has no effect
    issue(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b1, "ignore_restart");
    @(posedge clk1);
    #1;
    X     = 16'hAAAA;
    Y     = 16'h5555;
    start = 1'b1;
    @(posedge clk1);
    #1;
    start = 1'b0;
    wait_done("ignore_restart", n);
    repeat (10) @(negedge clk1);

    // Asynchronous reset in the third RUN cycle discards the partial result
    issue(16'h1234, 16'h4321, 1'b0, 16'h0000, 1'b0, 1'b0, "aborted");
    repeat (3) @(posedge clk1);
    #2;
    rst1 = 1'b1;
    #1;
    check("midrun_busy", 32'(busy), 32'd0);
    check("midrun_done", 32'(done), 32'd0);
    check("midrun_sum", 32'(Sum), 32'd0);
    check("midrun_c", 32'(C), 32'd0);
    @(posedge clk1);
    #1;
    rst1 = 1'b0;
    issue(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b1, "after_reset");
    wait_done("after_reset", n);
    check("latency_after_reset", 32'(n - 1), 32'(NIB + 1));

`ifdef NIBBLE_SUB_EN
    issue(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b1, "sub_neg");
    wait_done("sub_neg", n);
    issue(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b1, "sub_pos");
    wait_done("sub_pos", n);
    issue(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1, "sub_eq");
    wait_done("sub_eq", n);
    issue(16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0, 1'b1, "sub_off");
    wait_done("sub_off", n);
`endif

    // Back-to-back: start held high, one operation accepted every NIB+2 cycles
    @(posedge clk1);
    #1;
    X     = 16'hFEDC;
    Y     = 16'h1234;
    sub_r = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back('{sum: 16'h1110, c: 1'b1, tag: "b2b"});
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk1);
      if (done) done_cyc.push_back(cyc);
      if (cyc == 14) start = 1'b0;
    end
    check("b2b_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      check("b2b_first", 32'(done_cyc[0]), 32'd7);
      check("b2b_period_1", 32'(done_cyc[1] - done_cyc[0]), 32'(NIB + 2));
      check("b2b_period_2", 32'(done_cyc[2] - done_cyc[1]), 32'(NIB + 2));
    end

    repeat (10) @(negedge clk1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
